maze_tile_painter: RTL
======================

Name: maze_tile_painter

Overview:
Parametrised tile rasteriser for the maze display. It accepts one tile command: grid coordinates, four wall flags, a visited flag and a robot-present flag. It then streams every pixel of that tile, one per cycle, to the frame-buffer write port. Compared with the fixed 30x30 drawer it generalises tile size, wall thickness, grid size and colour depth, and adds start/busy/done handshaking, frame-buffer backpressure, out-of-range rejection and a robot marker.

Parameters:
TILE_SIZE, 30, tile edge in pixels (>=4)
WALL_W, 6, wall thickness in pixels (1..TILE_SIZE/2)
GRID_COLS, 9, tiles per row
GRID_ROWS, 9, tiles per column
ADDR_W, 15, width of each pixel address output
COLOR_W, 8, pixel colour width (RGB332 at default)
WALL_COLOR, 8'hE0, wall pixel colour
VISITED_COLOR, 8'hF4, floor colour for a visited tile
UNVISITED_COLOR, 8'h00, floor colour for an unvisited tile
ROBOT_COLOR, 8'h03, robot marker colour
MARK_LO, 12, first offset of the square robot marker (inclusive)
MARK_HI, 17, last offset of the square robot marker (inclusive)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  command strobe; sampled only in IDLE
tile_col  in  $clog2(GRID_COLS)  tile column index
tile_row  in  $clog2(GRID_ROWS)  tile row index
walls  in  4  {north, east, south, west}; 1 = wall present
visited  in  1  tile visited
robot_here  in  1  draw robot marker
fb_ready  in  1  frame buffer accepts a write this cycle
x_addr  out  ADDR_W  pixel x address
y_addr  out  ADDR_W  pixel y address
pixel  out  COLOR_W  pixel colour
W_EN  out  1  write strobe
busy  out  1  command in progress
done  out  1  one-cycle pulse after the final pixel write
err  out  1  one-cycle pulse when a command is rejected

Behaviour:
- Reset:
  - State returns to IDLE.
  - x_addr, y_addr, pixel, W_EN, busy, done and err all go to 0.
  - A reset that arrives mid-tile aborts the tile: no done pulse, and no further W_EN.
- Accepting a command (IDLE with start=1 at cycle 0):
  - If tile_col >= GRID_COLS or tile_row >= GRID_ROWS: err=1 in cycle 1, state stays IDLE, no writes.
  - Otherwise, at cycle 0 latch walls, visited, robot_here and the tile origin (ox = tile_col*TILE_SIZE, oy = tile_row*TILE_SIZE, constant multiply, ADDR_W wide). Go to PAINT with offsets xo=0, yo=0. busy=1 from cycle 1.
- PAINT:
  - Outputs are registered. In cycle 1, W_EN=1, x_addr=ox+xo, y_addr=oy+yo, and pixel carries the colour for (xo, yo).
  - Offsets advance row-major: xo increments; when xo=TILE_SIZE-1, xo wraps to 0 and yo increments.
  - Advance happens only on a cycle where W_EN=1 and fb_ready=1 (the beat is accepted).
  - When fb_ready=0, W_EN, address and pixel hold unchanged (stable until accepted).
  - When the beat with xo=yo=TILE_SIZE-1 is accepted, go to DONE.
  - Exactly TILE_SIZE^2 accepted beats per tile, with no duplicates and no gaps.
  - Latency with fb_ready held high: first write in cycle 1, last write in cycle TILE_SIZE^2.
- DONE:
  - Lasts one cycle: W_EN=0, done=1, busy=0, then IDLE.
  - With fb_ready always high, done appears in cycle TILE_SIZE^2+1.
  - A start in the DONE cycle is ignored; the next start is accepted in the following IDLE cycle.
- start while busy is ignored; latched inputs are unaffected by later input changes.
- Colour priority, first match wins:
  1. Wall: (N and yo<WALL_W), (S and yo>=TILE_SIZE-WALL_W), (W and xo<WALL_W) or (E and xo>=TILE_SIZE-WALL_W) → WALL_COLOR.
  2. Robot: robot_here and MARK_LO<=xo<=MARK_HI and MARK_LO<=yo<=MARK_HI → ROBOT_COLOR.
  3. Floor: visited ? VISITED_COLOR : UNVISITED_COLOR.
- Address width: GRID_COLS*TILE_SIZE-1 must fit in ADDR_W, and likewise for rows. This is an elaboration-time check that fails on violation; addresses never wrap at runtime.

Decomposition:
- Shared package maze_disp_pkg holds:
  - wall bit index constants (N=3, E=2, S=1, W=0);
  - default colour constants;
  - the state enum {IDLE, PAINT, DONE}.
- One sub-module is natural: tile_color_lut, purely combinational, mapping (xo, yo, walls, visited, robot_here) → pixel colour. It is reused by the minimap renderer.
- The offset counters and FSM stay in the top level.

Test Plan:
- Command col=2, row=1, walls=4'b0000, visited=1, robot_here=0, fb_ready=1 → 900 writes. First (60,30), last (89,59), all 8'hF4; done in cycle 901.
- col=0, row=0, walls=4'b1111, visited=0 → (5,5) WALL; (6,6) 8'h00; (24,24) WALL; (23,23) 8'h00.
- robot_here=1, walls=4'b1000, visited=1 → (12,12)..(17,17) ROBOT_COLOR; (12,3) WALL; (11,12) 8'hF4.
- Toggle fb_ready every other cycle → still exactly 900 accepted beats, addresses held while stalled; done 1 cycle after the last accept.
- tile_col=9 → err pulse in cycle 1, busy stays 0, no W_EN.
- Reset asserted at beat 400, then a new start → after reset all outputs are 0 with no done. The new tile starts at offset (0,0) and completes normally.

Source files
------------

// File: rtl/maze_disp_pkg.sv
// Shared definitions for the maze display renderers: wall bit positions,
// default RGB332 colours and the tile painter state encoding.
package maze_disp_pkg;

   // Bit positions inside the 4-bit walls vector {north, east, south, west}
   localparam int WALL_BIT_N = 3;
   localparam int WALL_BIT_E = 2;
   localparam int WALL_BIT_S = 1;
   localparam int WALL_BIT_W = 0;

   localparam logic [7:0] DEF_WALL_COLOR      = 8'hE0;
   localparam logic [7:0] DEF_VISITED_COLOR   = 8'hF4;
   localparam logic [7:0] DEF_UNVISITED_COLOR = 8'h00;
   localparam logic [7:0] DEF_ROBOT_COLOR     = 8'h03;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PAINT = 2'd1,
      DONE  = 2'd2
   } paint_state_t;

endpackage

// File: rtl/tile_color_lut.sv
// Combinational colour lookup for one pixel of a maze tile.
// Priority: wall band, then robot marker square, then floor colour.
import maze_disp_pkg::*;

module tile_color_lut #(
   parameter int                 TILE_SIZE       = 30,
   parameter int                 WALL_W          = 6,
   parameter int                 OFF_W           = 5,
   parameter int                 COLOR_W         = 8,
   parameter int                 MARK_LO         = 12,
   parameter int                 MARK_HI         = 17,
   parameter logic [COLOR_W-1:0] WALL_COLOR      = COLOR_W'(DEF_WALL_COLOR),
   parameter logic [COLOR_W-1:0] VISITED_COLOR   = COLOR_W'(DEF_VISITED_COLOR),
   parameter logic [COLOR_W-1:0] UNVISITED_COLOR = COLOR_W'(DEF_UNVISITED_COLOR),
   parameter logic [COLOR_W-1:0] ROBOT_COLOR     = COLOR_W'(DEF_ROBOT_COLOR)
) (
   input  logic [OFF_W-1:0]   i_xo,
   input  logic [OFF_W-1:0]   i_yo,
   input  logic [3:0]         i_walls,
   input  logic               i_visited,
   input  logic               i_robot,
   output logic [COLOR_W-1:0] o_color
);

   int   w_x;
   int   w_y;
   logic w_wall;
   logic w_mark;

   // Classify the pixel and pick its colour by priority
   always_comb begin
      w_x    = int'(i_xo);
      w_y    = int'(i_yo);
      w_wall = (i_walls[WALL_BIT_N] && (w_y <  WALL_W))
            || (i_walls[WALL_BIT_S] && (w_y >= TILE_SIZE - WALL_W))
            || (i_walls[WALL_BIT_W] && (w_x <  WALL_W))
            || (i_walls[WALL_BIT_E] && (w_x >= TILE_SIZE - WALL_W));
      w_mark = i_robot
            && (w_x >= MARK_LO) && (w_x <= MARK_HI)
            && (w_y >= MARK_LO) && (w_y <= MARK_HI);
      if (w_wall) begin
         o_color = WALL_COLOR;
      end else if (w_mark) begin
         o_color = ROBOT_COLOR;
      end else if (i_visited) begin
         o_color = VISITED_COLOR;
      end else begin
         o_color = UNVISITED_COLOR;
      end
   end

endmodule

// File: rtl/maze_tile_painter.sv
// Tile rasteriser: takes one tile command and streams its TILE_SIZE^2
// pixels row-major to the frame buffer, one accepted beat per fb_ready.
//
// state | meaning
// IDLE  | waiting for start; out-of-range commands pulse err
// PAINT | presenting beat (xo,yo); advances when W_EN && fb_ready
// DONE  | one-cycle done pulse, start ignored, then back to IDLE
import maze_disp_pkg::*;

module maze_tile_painter #(
   parameter int                 TILE_SIZE       = 30,
   parameter int                 WALL_W          = 6,
   parameter int                 GRID_COLS       = 9,
   parameter int                 GRID_ROWS       = 9,
   parameter int                 ADDR_W          = 15,
   parameter int                 COLOR_W         = 8,
   parameter logic [COLOR_W-1:0] WALL_COLOR      = COLOR_W'(DEF_WALL_COLOR),
   parameter logic [COLOR_W-1:0] VISITED_COLOR   = COLOR_W'(DEF_VISITED_COLOR),
   parameter logic [COLOR_W-1:0] UNVISITED_COLOR = COLOR_W'(DEF_UNVISITED_COLOR),
   parameter logic [COLOR_W-1:0] ROBOT_COLOR     = COLOR_W'(DEF_ROBOT_COLOR),
   parameter int                 MARK_LO         = 12,
   parameter int                 MARK_HI         = 17
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [$clog2(GRID_COLS)-1:0]  tile_col,
   input  logic [$clog2(GRID_ROWS)-1:0]  tile_row,
   input  logic [3:0]                    walls,
   input  logic                          visited,
   input  logic                          robot_here,
   input  logic                          fb_ready,
   output logic [ADDR_W-1:0]             x_addr,
   output logic [ADDR_W-1:0]             y_addr,
   output logic [COLOR_W-1:0]            pixel,
   output logic                          W_EN,
   output logic                          busy,
   output logic                          done,
   output logic                          err
);

   localparam int OFF_W = $clog2(TILE_SIZE);
   localparam int LAST  = TILE_SIZE - 1;

   // Parameter sanity: these must fail the build rather than misbehave
   if (TILE_SIZE < 4) begin : g_chk_tile
      $error("maze_tile_painter: TILE_SIZE must be at least 4");
   end
   if ((WALL_W < 1) || (WALL_W > TILE_SIZE / 2)) begin : g_chk_wall
      $error("maze_tile_painter: WALL_W must lie in 1..TILE_SIZE/2");
   end
   if ((longint'(GRID_COLS) * TILE_SIZE - 1) >= (longint'(1) << ADDR_W)) begin : g_chk_xw
      $error("maze_tile_painter: ADDR_W too narrow for GRID_COLS*TILE_SIZE");
   end
   if ((longint'(GRID_ROWS) * TILE_SIZE - 1) >= (longint'(1) << ADDR_W)) begin : g_chk_yw
      $error("maze_tile_painter: ADDR_W too narrow for GRID_ROWS*TILE_SIZE");
   end
   if ((MARK_LO > MARK_HI) || (MARK_HI >= TILE_SIZE)) begin : g_chk_mark
      $error("maze_tile_painter: robot marker must fit inside the tile");
   end

   paint_state_t       r_state;
   paint_state_t       w_state_nxt;

   logic [OFF_W-1:0]   r_xo;
   logic [OFF_W-1:0]   r_yo;
   logic [OFF_W-1:0]   w_xo_nxt;
   logic [OFF_W-1:0]   w_yo_nxt;

   logic [3:0]         r_walls;
   logic               r_visited;
   logic               r_robot;
   logic [ADDR_W-1:0]  r_ox;
   logic [ADDR_W-1:0]  r_oy;

   logic [ADDR_W-1:0]  r_x_addr;
   logic [ADDR_W-1:0]  r_y_addr;
   logic [COLOR_W-1:0] r_pixel;
   logic               r_wen;
   logic               r_busy;
   logic               r_done;
   logic               r_err;

   logic               w_wen_nxt;
   logic               w_busy_nxt;
   logic               w_done_nxt;
   logic               w_err_nxt;
   logic               w_load;
   logic               w_emit;

   logic [3:0]         w_sel_walls;
   logic               w_sel_visited;
   logic               w_sel_robot;
   logic [ADDR_W-1:0]  w_sel_ox;
   logic [ADDR_W-1:0]  w_sel_oy;
   logic [ADDR_W-1:0]  w_ox_in;
   logic [ADDR_W-1:0]  w_oy_in;
   logic [COLOR_W-1:0] w_color;

   logic               w_in_range;
   logic               w_accept;
   logic               w_last;

   assign w_in_range = (int'(tile_col) < GRID_COLS) && (int'(tile_row) < GRID_ROWS);
   assign w_ox_in    = ADDR_W'(tile_col) * ADDR_W'(TILE_SIZE);
   assign w_oy_in    = ADDR_W'(tile_row) * ADDR_W'(TILE_SIZE);
   assign w_accept   = r_wen && fb_ready;
   assign w_last     = (r_xo == OFF_W'(LAST)) && (r_yo == OFF_W'(LAST));

   // Colour of the beat about to be registered. On the start cycle the
   // command inputs are used directly, since they are only being latched now.
   tile_color_lut #(
      .TILE_SIZE       (TILE_SIZE),
      .WALL_W          (WALL_W),
      .OFF_W           (OFF_W),
      .COLOR_W         (COLOR_W),
      .MARK_LO         (MARK_LO),
      .MARK_HI         (MARK_HI),
      .WALL_COLOR      (WALL_COLOR),
      .VISITED_COLOR   (VISITED_COLOR),
      .UNVISITED_COLOR (UNVISITED_COLOR),
      .ROBOT_COLOR     (ROBOT_COLOR)
   ) u_lut (
      .i_xo      (w_xo_nxt),
      .i_yo      (w_yo_nxt),
      .i_walls   (w_sel_walls),
      .i_visited (w_sel_visited),
      .i_robot   (w_sel_robot),
      .o_color   (w_color)
   );

   // Next-state, offset advance and registered-output targets
   always_comb begin
      w_state_nxt   = r_state;
      w_xo_nxt      = r_xo;
      w_yo_nxt      = r_yo;
      w_wen_nxt     = r_wen;
      w_busy_nxt    = r_busy;
      w_done_nxt    = 1'b0;
      w_err_nxt     = 1'b0;
      w_load        = 1'b0;
      w_emit        = 1'b0;
      w_sel_walls   = r_walls;
      w_sel_visited = r_visited;
      w_sel_robot   = r_robot;
      w_sel_ox      = r_ox;
      w_sel_oy      = r_oy;

      case (r_state)
         IDLE: begin
            w_sel_walls   = walls;
            w_sel_visited = visited;
            w_sel_robot   = robot_here;
            w_sel_ox      = w_ox_in;
            w_sel_oy      = w_oy_in;
            if (start) begin
               if (!w_in_range) begin
                  w_err_nxt = 1'b1;
               end else begin
                  w_state_nxt = PAINT;
                  w_load      = 1'b1;
                  w_emit      = 1'b1;
                  w_xo_nxt    = '0;
                  w_yo_nxt    = '0;
                  w_wen_nxt   = 1'b1;
                  w_busy_nxt  = 1'b1;
               end
            end
         end
         PAINT: begin
            if (w_accept) begin
               if (w_last) begin
                  w_state_nxt = DONE;
                  w_wen_nxt   = 1'b0;
                  w_busy_nxt  = 1'b0;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_emit = 1'b1;
                  if (r_xo == OFF_W'(LAST)) begin
                     w_xo_nxt = '0;
                     w_yo_nxt = r_yo + 1'b1;
                  end else begin
                     w_xo_nxt = r_xo + 1'b1;
                  end
               end
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
            w_wen_nxt   = 1'b0;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Offsets, latched command and registered frame-buffer outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_xo      <= '0;
         r_yo      <= '0;
         r_walls   <= '0;
         r_visited <= 1'b0;
         r_robot   <= 1'b0;
         r_ox      <= '0;
         r_oy      <= '0;
         r_x_addr  <= '0;
         r_y_addr  <= '0;
         r_pixel   <= '0;
         r_wen     <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_xo   <= w_xo_nxt;
         r_yo   <= w_yo_nxt;
         r_wen  <= w_wen_nxt;
         r_busy <= w_busy_nxt;
         r_done <= w_done_nxt;
         r_err  <= w_err_nxt;
         if (w_load) begin
            r_walls   <= walls;
            r_visited <= visited;
            r_robot   <= robot_here;
            r_ox      <= w_ox_in;
            r_oy      <= w_oy_in;
         end
         if (w_emit) begin
            r_x_addr <= w_sel_ox + ADDR_W'(w_xo_nxt);
            r_y_addr <= w_sel_oy + ADDR_W'(w_yo_nxt);
            r_pixel  <= w_color;
         end
      end
   end

   assign x_addr = r_x_addr;
   assign y_addr = r_y_addr;
   assign pixel  = r_pixel;
   assign W_EN   = r_wen;
   assign busy   = r_busy;
   assign done   = r_done;
   assign err    = r_err;

endmodule
